apb_master_bridge: RTL and testbench

- Upstream APB4 requester that drives the memory-backed APB slave.
- Accepts one command at a time on a valid/ready command port and runs the full APB4 SETUP/ACCESS sequence, honouring PREADY wait states.
- Returns read data and error status on a valid/ready response port.
- All APB outputs are registered; one transfer in flight at most.

---
 rtl/apb_master_bridge.sv | 149 ++++++++++++++
 tb/tb_apb_master_bridge.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB4 requester: one command in, full SETUP/ACCESS sequence out, one response back.
// Optional wait-state timeout in ACCESS, enabled by defining APB_MASTER_TIMEOUT_EN.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif
`ifndef APB_STRB_WIDTH
`define APB_STRB_WIDTH 4
`endif
`ifndef APB_PROT_WIDTH
`define APB_PROT_WIDTH 3
`endif

module apb_master_bridge #(
  parameter int ADDR_WIDTH     = `APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = `APB_DATA_WIDTH,
  parameter int STRB_WIDTH     = `APB_STRB_WIDTH,
  parameter int PROT_WIDTH     = `APB_PROT_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_strb,
  input  logic [PROT_WIDTH-1:0] cmd_prot,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic [STRB_WIDTH-1:0] PSTRB,
  output logic [PROT_WIDTH-1:0] PPROT,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t state, state_n;
  logic   accept, done, abort;
  logic   timeout_hit;

  assign cmd_ready = (state == IDLE);

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && !PREADY) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // this low-PREADY cycle would make the count reach the limit
  assign timeout_hit = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          state_n = SETUP;
        end
      end
      SETUP: state_n = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          done    = 1'b1;
          state_n = RESP;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_n = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state       <= IDLE;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      PPROT       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        PSEL   <= 1'b1;
        PWRITE <= cmd_write;
        PADDR  <= cmd_addr;
        PPROT  <= cmd_prot;
        // reads carry no data and no strobes on the bus
        PWDATA <= cmd_write ? cmd_wdata : '0;
        PSTRB  <= cmd_write ? cmd_strb : '0;
      end
      if (state == SETUP) PENABLE <= 1'b1;
      if (done || abort) begin
        PSEL        <= 1'b0;
        PENABLE     <= 1'b0;
        rsp_valid   <= 1'b1;
        rsp_rdata   <= (done && !PWRITE) ? PRDATA : '0;
        rsp_err     <= done ? PSLVERR : 1'b1;
        rsp_timeout <= abort;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: wait-state slave, timeline model, per-cycle compare.
module tb_apb_master_bridge;

  localparam int TO = 16;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        PCLK = 0;
  logic        PRESETn = 0;
  logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0;
  logic [3:0]  cmd_strb = 0;
  logic [2:0]  cmd_prot = 0;
  logic        rsp_valid, rsp_ready = 0;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic        PREADY, PSLVERR;

  apb_master_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4),
    .PROT_WIDTH(3), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rst_seen = 0;
  logic started = 0;

  always @(posedge PCLK) begin
    cyc <= cyc + 1;
    rst_seen <= !PRESETn;
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  // slave: memory, programmable wait states, error and forced read data
  logic [31:0] mem [16];
  int   s_waits = 0;
  int   acc_n = 0;
  logic s_err = 0, s_force = 0;
  logic [31:0] s_fval = 0;

  assign PREADY  = PSEL && PENABLE && (acc_n >= s_waits);
  assign PSLVERR = s_err;
  assign PRDATA  = s_force ? s_fval : mem[PADDR[3:0]];

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_n <= acc_n + 1;
    else acc_n <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE)
      for (int b = 0; b < 4; b++)
        if (PSTRB[b]) mem[PADDR[3:0]][8*b+:8] <= PWDATA[8*b+:8];
  end

  // model: timeline of the current transfer, in cycle indices
  logic [31:0] m_mem [16];
  logic        m_on = 0, m_write = 0, m_err = 0, m_to = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
  logic [3:0]  m_strb = 0;
  logic [2:0]  m_prot = 0;
  int          m_c = 0, m_len = 0, m_d = 0, m_end = 0;

  always @(negedge PCLK) begin
    int  k;
    logic in_t, e_sel, e_en, e_rv, e_cr;
    k = cyc;
    if (started && rst_seen) begin
      chk("rst_psel", PSEL, 0);
      chk("rst_penable", PENABLE, 0);
      chk("rst_pwrite", PWRITE, 0);
      chk("rst_paddr", PADDR, 0);
      chk("rst_pwdata", PWDATA, 0);
      chk("rst_pstrb", PSTRB, 0);
      chk("rst_pprot", PPROT, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_timeout", rsp_timeout, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
    end else if (started) begin
      in_t  = m_on && k > m_c && k < m_end;
      e_sel = in_t && k <= m_c + 1 + m_len;
      e_en  = in_t && k >= m_c + 2 && k <= m_c + 1 + m_len;
      e_rv  = in_t && k >= m_c + 2 + m_len && k <= m_c + 2 + m_len + m_d;
      e_cr  = !(in_t && k <= m_c + 2 + m_len + m_d);
      chk("psel", PSEL, e_sel);
      chk("penable", PENABLE, e_en);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("cmd_ready", cmd_ready, e_cr);
      if (e_sel) begin
        chk("pwrite", PWRITE, m_write);
        chk("paddr", PADDR, m_addr);
        chk("pwdata", PWDATA, m_wdata);
        chk("pstrb", PSTRB, m_strb);
        chk("pprot", PPROT, m_prot);
      end
      if (e_rv) begin
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", rsp_err, m_err);
        chk("rsp_timeout", rsp_timeout, m_to);
      end
    end
  end

  logic [31:0] got_rdata;
  logic        got_err, got_to;

  // called #1 after an edge; d = extra cycles rsp_ready stays low
  task automatic xfer(input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input logic [2:0] prot, input int w,
                      input logic err, input logic frc,
                      input logic [31:0] fval, input int d,
                      input logic rst_mid);
    logic to;
    s_waits = w; s_err = err; s_force = frc; s_fval = fval;
    to      = TO_EN && (w >= TO);
    m_c     = cyc;
    m_write = wr;
    m_addr  = addr;
    m_wdata = wr ? wdata : 0;
    m_strb  = wr ? strb : 4'h0;
    m_prot  = prot;
    m_d     = d;
    m_end   = 32'h7fff_ffff;
    m_len   = to ? TO : w + 1;
    m_to    = to;
    m_err   = to ? 1'b1 : err;
    m_rdata = (wr || to) ? 0 : (frc ? fval : m_mem[addr[3:0]]);
    if (wr && !to && !rst_mid)
      for (int b = 0; b < 4; b++)
        if (strb[b]) m_mem[addr[3:0]][8*b+:8] = wdata[8*b+:8];
    m_on = 1;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    cmd_strb = strb; cmd_prot = prot; cmd_valid = 1;
    @(posedge PCLK); #1;
    cmd_valid = 0;
    if (rst_mid) begin
      repeat (2) begin @(posedge PCLK); #1; end
      PRESETn = 0;
      m_end = m_c + 4;
      @(posedge PCLK); #1;
      PRESETn = 1;
    end else begin
      for (int g = 0; g < 200 && cyc < m_c + 2 + m_len + d; g++) begin
        @(posedge PCLK); #1;
      end
      got_rdata = rsp_rdata; got_err = rsp_err; got_to = rsp_timeout;
      rsp_ready = 1;
      @(posedge PCLK); #1;
      rsp_ready = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin mem[i] = 0; m_mem[i] = 0; end
    repeat (2) @(posedge PCLK);
    #1 started = 1;
    @(posedge PCLK); #1;
    PRESETn = 1;
    @(posedge PCLK); #1;
    xfer(1, 32'h05, 32'hDEADBEEF, 4'hF, 3'b000, 0, 0, 0, 0, 0, 0);
    chk("t1_rdata", got_rdata, 32'h0);
    chk("t1_err", got_err, 0);
    xfer(0, 32'h05, 32'h0, 4'hF, 3'b010, 0, 0, 0, 0, 0, 0);
    chk("t2_rdata", got_rdata, 32'hDEADBEEF);
    chk("t2_err", got_err, 0);
    xfer(0, 32'h05, 32'h0, 4'h0, 3'b001, 3, 0, 0, 0, 0, 0);
    chk("t3_rdata", got_rdata, 32'hDEADBEEF);
    xfer(0, 32'h09, 32'h0, 4'h0, 3'b000, 0, 1, 1, 32'h12345678, 0, 0);
    chk("t4_rdata", got_rdata, 32'h12345678);
    chk("t4_err", got_err, 1);
    xfer(0, 32'h05, 32'h0, 4'h0, 3'b000, 0, 0, 0, 0, 4, 0);
    chk("t5_rdata", got_rdata, 32'hDEADBEEF);
    xfer(1, 32'h06, 32'hA5A51234, 4'h3, 3'b101, 1, 0, 0, 0, 0, 0);
    xfer(0, 32'h06, 32'h0, 4'h0, 3'b000, 0, 0, 0, 0, 1, 0);
    chk("strb3_rdata", got_rdata, 32'h00001234);
    xfer(1, 32'h05, 32'h11111111, 4'h0, 3'b000, 0, 0, 0, 0, 0, 0);
    xfer(0, 32'h05, 32'h0, 4'h0, 3'b000, 0, 0, 0, 0, 0, 0);
    chk("strb0_rdata", got_rdata, 32'hDEADBEEF);
    xfer(1, 32'h07, 32'hCAFEF00D, 4'hF, 3'b000, 2, 1, 0, 0, 0, 0);
    chk("werr_rdata", got_rdata, 32'h0);
    chk("werr_err", got_err, 1);
    xfer(0, 32'h05, 32'h0, 4'h0, 3'b000, 5, 0, 0, 0, 0, 1);
    xfer(0, 32'h05, 32'h0, 4'h0, 3'b000, 0, 0, 0, 0, 0, 0);
    chk("postrst_rdata", got_rdata, 32'hDEADBEEF);
`ifdef APB_MASTER_TIMEOUT_EN
    xfer(0, 32'h05, 32'h0, 4'h0, 3'b000, 15, 0, 0, 0, 0, 0);
    chk("w15_timeout", got_to, 0);
    chk("w15_rdata", got_rdata, 32'hDEADBEEF);
    xfer(0, 32'h05, 32'h0, 4'h0, 3'b000, 16, 0, 0, 0, 0, 0);
    chk("w16_timeout", got_to, 1);
    xfer(0, 32'h05, 32'h0, 4'h0, 3'b000, 40, 0, 0, 0, 2, 0);
    chk("stuck_timeout", got_to, 1);
    chk("stuck_err", got_err, 1);
    chk("stuck_rdata", got_rdata, 32'h0);
`endif
    repeat (3) @(posedge PCLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
